// File: rtl/spi_flash_responder.sv
// SPI mode-0 READ (0x03) responder emulating the program flash; backing store
// is an internal byte array written through a host load port while idle.
module spi_flash_responder #(
  parameter int          ADDR_BITS = 8,
  parameter logic [7:0]  READ_CMD  = 8'h03
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_cs_i,
  input  logic                 spi_sclk_i,
  input  logic                 spi_mosi_i,
  output logic                 spi_miso_o,
  output logic                 spi_miso_oe,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_IGNORE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic r_cs_s1, r_cs_s2, r_cs_prev;
  logic r_sclk_s1, r_sclk_s2, r_sclk_prev;
  logic r_mosi_s1, r_mosi_s2;

  logic [4:0]           r_cnt;
  logic [6:0]           r_cmd;
  logic [ADDR_BITS-2:0] r_addr;
  logic [ADDR_BITS-1:0] r_ptr;
  logic [6:0]           r_shift;
  logic                 r_miso;
  logic                 r_oe;

  logic [7:0] r_mem [DEPTH];

  logic                 w_cs_fall, w_cs_rise;
  logic                 w_sclk_rise, w_sclk_fall;
  logic [7:0]           w_cmd;
  logic [ADDR_BITS-1:0] w_addr;
  logic [7:0]           w_rd_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_s1     <= 1'b0;
      r_cs_s2     <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_mosi_s1   <= 1'b0;
      r_mosi_s2   <= 1'b0;
    end else begin
      r_cs_s1     <= spi_cs_i;
      r_cs_s2     <= r_cs_s1;
      r_cs_prev   <= r_cs_s2;
      r_sclk_s1   <= spi_sclk_i;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_mosi_s1   <= spi_mosi_i;
      r_mosi_s2   <= r_mosi_s1;
    end
  end

  // Synchronizers reset low, so a cs already low at reset release shows no edge.
  assign w_cs_fall   = r_cs_prev & ~r_cs_s2;
  assign w_cs_rise   = ~r_cs_prev & r_cs_s2;
  assign w_sclk_rise = ~r_sclk_prev & r_sclk_s2;
  assign w_sclk_fall = r_sclk_prev & ~r_sclk_s2;

  assign w_cmd     = {r_cmd, r_mosi_s2};
  assign w_addr    = {r_addr, r_mosi_s2};
  assign w_rd_byte = r_mem[r_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_cs_rise) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cs_fall) w_state_next = S_CMD;
        S_CMD:   if (w_sclk_rise && r_cnt == 5'd7)
                   w_state_next = (w_cmd == READ_CMD) ? S_ADDR : S_IGNORE;
        S_ADDR:  if (w_sclk_rise && r_cnt == 5'd23) w_state_next = S_DATA;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_cmd   <= '0;
      r_addr  <= '0;
      r_ptr   <= '0;
      r_shift <= '0;
      r_miso  <= 1'b0;
      r_oe    <= 1'b0;
    end else if (w_cs_rise) begin
      r_miso <= 1'b0;
      r_oe   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_miso <= 1'b0;
          r_oe   <= 1'b0;
          if (w_cs_fall) r_cnt <= '0;
        end
        S_CMD: begin
          if (w_sclk_rise) begin
            r_cmd <= w_cmd[6:0];
            r_cnt <= (r_cnt == 5'd7) ? 5'd0 : r_cnt + 5'd1;
          end
        end
        S_ADDR: begin
          // Only the low ADDR_BITS of the 24-bit address survive the shift.
          if (w_sclk_rise) begin
            r_addr <= w_addr[ADDR_BITS-2:0];
            if (r_cnt == 5'd23) begin
              r_ptr <= w_addr;
              r_cnt <= '0;
              r_oe  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        S_DATA: begin
          if (w_sclk_fall) begin
            if (r_cnt[2:0] == 3'd0) begin
              r_miso  <= w_rd_byte[7];
              r_shift <= w_rd_byte[6:0];
              r_ptr   <= r_ptr + ADDR_BITS'(1);
            end else begin
              r_miso  <= r_shift[6];
              r_shift <= {r_shift[5:0], 1'b0};
            end
          end else if (w_sclk_rise) begin
            r_cnt <= {2'b00, r_cnt[2:0] + 3'd1};
          end
        end
        default: begin
          r_miso <= 1'b0;
          r_oe   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && r_state == S_IDLE) r_mem[load_addr] <= load_data;
  end

  assign spi_miso_o  = r_miso;
  assign spi_miso_oe = r_oe;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder: a bit-banged SPI master reads
// frames and compares against a byte-array model of the flash contents.
module tb_spi_flash_responder;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_cs, spi_sclk, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic       load_en;
  logic [7:0] load_addr, load_data;
  logic       busy;

  logic [7:0] mem_m [256];
  int n_vec = 0;
  int n_err = 0;

  spi_flash_responder #(
    .ADDR_BITS (8),
    .READ_CMD  (8'h03)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs_i    (spi_cs),
    .spi_sclk_i  (spi_sclk),
    .spi_mosi_i  (spi_mosi),
    .spi_miso_o  (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic host_load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic spi_bit(input logic b, output logic r, output logic oe);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    r  = spi_miso;
    oe = spi_miso_oe;
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    logic r, o;
    oe_all = 1'b1; oe_any = 1'b0; rx = '0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r, o);
      rx[i]  = r;
      oe_all = oe_all & o;
      oe_any = oe_any | o;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic end_frame(input string tag);
    repeat (HALF) @(negedge clk);
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".oe_end"}, spi_miso_oe, 0);
    check({tag, ".miso_end"}, spi_miso, 0);
  endtask

  // mode 0: plain frame; 1: load attempted while busy (must be dropped);
  // 2: load issued in the cycle the cs falling edge is seen (must land).
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [23:0] addr,
                           input int nbytes, input int mode, input logic [7:0] ld_data);
    logic [7:0] rx, a;
    logic oa, oy, hdr_oe;
    @(negedge clk);
    spi_cs = 1'b0;
    if (mode == 2) begin
      @(negedge clk);
      @(negedge clk);
      load_en = 1'b1; load_addr = addr[7:0]; load_data = ld_data;
      mem_m[addr[7:0]] = ld_data;
      @(negedge clk);
      load_en = 1'b0;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    check({tag, ".busy"}, busy, 1);
    spi_byte(cmd, rx, oa, hdr_oe);
    if (mode == 1) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = addr[7:0]; load_data = ld_data;
      @(negedge clk);
      load_en = 1'b0;
    end
    for (int i = 2; i >= 0; i--) begin
      spi_byte(addr[i*8 +: 8], rx, oa, oy);
      hdr_oe = hdr_oe | oy;
    end
    check({tag, ".hdr_oe"}, hdr_oe, 0);
    a = addr[7:0];
    for (int k = 0; k < nbytes; k++) begin
      spi_byte(8'h00, rx, oa, oy);
      if (cmd == 8'h03) begin
        check($sformatf("%s.data%0d", tag, k), rx, mem_m[a]);
        check($sformatf("%s.oe%0d", tag, k), oa, 1);
      end else begin
        check($sformatf("%s.ign_oe%0d", tag, k), oy, 0);
      end
      a = a + 8'd1;
    end
    end_frame(tag);
  endtask

  initial begin
    logic [7:0] rx, cmd;
    logic oa, oy, r, o, any_oe;
    logic [23:0] addr;
    int n, mode;

    rst = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.miso", spi_miso, 0);
    check("reset.oe", spi_miso_oe, 0);
    check("reset.busy", busy, 0);
    repeat (4) @(negedge clk);
    check("reset.busy_settled", busy, 0);

    for (int i = 0; i < 256; i++) host_load(8'(i), 8'($urandom));
    host_load(8'h10, 8'hA5);
    host_load(8'h11, 8'h3C);
    host_load(8'hFF, 8'h81);
    host_load(8'h00, 8'h7E);

    run_frame("basic", 8'h03, 24'h000010, 2, 0, 8'h00);
    run_frame("wrap", 8'h03, 24'h1234FF, 2, 0, 8'h00);
    run_frame("unknown", 8'h0B, 24'h000000, 2, 0, 8'h00);
    run_frame("after_unknown", 8'h03, 24'h000010, 1, 0, 8'h00);

    cs_low();
    spi_byte(8'h03, rx, oa, oy);
    for (int i = 0; i < 12; i++) spi_bit(1'b1, r, o);
    end_frame("abort");
    run_frame("after_abort", 8'h03, 24'h000011, 1, 0, 8'h00);

    cs_low();
    spi_byte(8'h03, rx, oa, oy);
    spi_byte(8'h00, rx, oa, oy);
    spi_byte(8'h00, rx, oa, oy);
    spi_byte(8'h10, rx, oa, oy);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r, o);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst_mid.oe", spi_miso_oe, 0);
    check("rst_mid.miso", spi_miso, 0);
    check("rst_mid.busy", busy, 0);
    any_oe = 1'b0;
    for (int i = 0; i < 16; i++) begin
      spi_bit(1'b1, r, o);
      any_oe = any_oe | o | busy;
    end
    check("rst_mid.ignored", any_oe, 0);
    end_frame("rst_mid");
    run_frame("after_rst", 8'h03, 24'h000010, 2, 0, 8'h00);

    run_frame("load_busy", 8'h03, 24'h000010, 1, 1, 8'hFF);
    run_frame("after_load_busy", 8'h03, 24'h000010, 1, 0, 8'h00);
    host_load(8'h10, 8'hFF);
    run_frame("load_idle", 8'h03, 24'h000010, 1, 0, 8'h00);
    run_frame("load_at_fall", 8'h03, 24'h000020, 1, 2, 8'h5B);

    for (int f = 0; f < 16; f++) begin
      if ($urandom_range(0, 1) == 1) host_load(8'($urandom), 8'($urandom));
      cmd = 8'h03;
      if ($urandom_range(0, 3) == 0) begin
        cmd = 8'($urandom);
        if (cmd == 8'h03) cmd = 8'h0B;
      end
      addr = 24'($urandom);
      n    = $urandom_range(1, 3);
      mode = $urandom_range(0, 2);
      run_frame($sformatf("rnd%0d", f), cmd, addr, n, mode, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
